add_round_key_sched: RTL
========================

Name: add_round_key_sched

Overview:
AddRoundKey stage with an on-the-fly AES-128 key schedule. It sits directly downstream of the MixColumns stage and consumes that stage's 128-bit row-major state and its done strobe as the enable. Each accepted operation XORs the state with the current round key, registers the result, and advances the key register to the next round key. No key storage exists outside this block.

Parameters:
NUM_ROUNDS, 10, last round index; after the add with round key NUM_ROUNDS the schedule is exhausted (legal range 1..10)

Ports:
pi_clk  input  1  clock, all state updates on rising edge
pi_rst  input  1  reset, synchronous, active-high
pi_load_key  input  1  single-cycle strobe; latches pi_key as round key 0
pi_key  input  128  cipher key, FIPS-197 byte order (key byte i = bits [127-8i -: 8]; word w_c = bits [127-32c -: 32])
pi_enable  input  1  operation request; normally driven by the upstream done strobe
pi_in  input  128  state, row-major (row r, column c = bits [127-8(4r+c) -: 8])
po_add_key_done  output  1  one-cycle strobe; po_out valid
po_out  output  128  state XOR round key, row-major, registered
po_round  output  4  index of the round key to be used by the next accepted op
po_key_ready  output  1  high while a round key is available (0..NUM_ROUNDS not yet consumed)

Behaviour:
- Clock is pi_clk; reset is pi_rst, synchronous, active-high.
- Reset values: po_out=0, po_add_key_done=0, po_round=0, po_key_ready=0; key register=0; rcon register=8'h01.
- Key load: pi_load_key=1 at an edge sets key register=pi_key, po_round=0, rcon=8'h01, po_key_ready=1. Load is accepted in any state, including mid-sequence.
- Accept: an op is accepted when pi_enable=1, po_key_ready=1 and pi_load_key=0.
- pi_enable=1 with po_key_ready=0: ignored; no done strobe; po_out holds.
- pi_load_key=1 and pi_enable=1 in the same cycle: load wins and the enable is dropped.
- Accepted op, results visible at the next edge (latency 1):
  - po_out = pi_in XOR transpose(key register). The state byte at (r,c) is XORed with byte r of word w_c.
  - po_add_key_done = 1 for exactly one cycle. Back-to-back enables give back-to-back strobes.
  - If po_round < NUM_ROUNDS: key register <= next key, po_round += 1, rcon <= xtime(rcon).
  - If po_round == NUM_ROUNDS: po_key_ready <= 0; key register and po_round hold.
- Next key (combinational from key register w0..w3):
  - t = SubWord(RotWord(w3)) XOR {rcon,24'h0}
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
- RotWord: {b1,b2,b3,b0}. SubWord applies the FIPS-197 forward S-box to each of the 4 bytes; implementation is a 256-entry table or GF(2^8) inverse plus affine transform, implementer's choice, purely combinational.
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). Sequence: 01,02,04,08,10,20,40,80,1b,36.
- po_out holds its value between accepted ops. po_add_key_done is 0 in every cycle without an accepted op.
- Reset mid-sequence: all registers return to reset values; a key load is required before any further op.

Optional Feature:
ARK_ROUND_KEY_OUT_EN:
- Defined: adds output port po_round_key[127:0], equal to the key register (FIPS word order), registered, reset 0; used for debug and for the decrypt key-capture path.
- Undefined: the port does not exist and there is no other behavioural change.

Test Plan:
- Reset, then pulse pi_enable=1 with no key loaded -> po_add_key_done stays 0, po_out=0, po_key_ready=0.
- Load key 2b7e151628aed2a6abf7158809cf4f3c, then enable with state 3243f6a8885a308d313198a2e0370734 (FIPS column order, bench transposes to row-major) -> one cycle later po_add_key_done=1, po_out = 193de3bea0f4e22b9ac68d2ae9f84808 transposed, po_round=1.
- Continue: enable with state 046681e5e0cb199a48f8d37a2806264c (transposed) -> po_out = a49c7ff2689f352b6b5bea43026a5049 transposed. With ARK_ROUND_KEY_OUT_EN, po_round_key sequence starts a0fafe1788542cb123a339392a6c7605.
- Issue 11 back-to-back enables after load -> 11 consecutive done strobes; round-10 key = d014f9a8c9ee2589e13f0cc8b6630ca6. After the 11th: po_key_ready=0, po_round=10, a 12th enable gives no strobe.
- pi_load_key and pi_enable asserted in the same cycle at po_round=5 -> no done strobe, po_round=0, po_key_ready=1, po_out unchanged.
- Assert pi_rst at po_round=3 with pi_enable high -> next edge: all outputs 0, po_key_ready=0; subsequent enables ignored until a load.

Source files
------------

// File: rtl/add_round_key_sched.sv
// AddRoundKey stage with an on-the-fly AES-128 key schedule (forward direction).
// Build option ARK_ROUND_KEY_OUT_EN exposes the current round key on po_round_key.
module add_round_key_sched #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         pi_clk,
    input  logic         pi_rst,
    input  logic         pi_load_key,
    input  logic [127:0] pi_key,
    input  logic         pi_enable,
    input  logic [127:0] pi_in,
    output logic         po_add_key_done,
    output logic [127:0] po_out,
    output logic [3:0]   po_round,
    output logic         po_key_ready
`ifdef ARK_ROUND_KEY_OUT_EN
    ,
    output logic [127:0] po_round_key
`endif
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    // Forward S-box, entry x at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Key words are column-major; state bytes are row-major, so swap (r,c) here.
    function automatic logic [127:0] transpose(input logic [127:0] k);
        logic [127:0] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[127 - 8 * (4 * r + c) -: 8] = k[127 - 32 * c - 8 * r -: 8];
            end
        end
        return t;
    endfunction

    logic [127:0] key_q;
    logic [7:0]   rcon_q;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  t_word;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic         accept;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign t_word = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
    assign nw0    = w0 ^ t_word;
    assign nw1    = w1 ^ nw0;
    assign nw2    = w2 ^ nw1;
    assign nw3    = w3 ^ nw2;

    assign accept = pi_enable && po_key_ready && !pi_load_key;

    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            key_q           <= '0;
            rcon_q          <= 8'h01;
            po_out          <= '0;
            po_add_key_done <= 1'b0;
            po_round        <= '0;
            po_key_ready    <= 1'b0;
        end else begin
            po_add_key_done <= 1'b0;
            if (pi_load_key) begin
                key_q        <= pi_key;
                rcon_q       <= 8'h01;
                po_round     <= '0;
                po_key_ready <= 1'b1;
            end else if (accept) begin
                po_out          <= pi_in ^ transpose(key_q);
                po_add_key_done <= 1'b1;
                if (po_round < LAST_ROUND) begin
                    key_q    <= {nw0, nw1, nw2, nw3};
                    rcon_q   <= xtime(rcon_q);
                    po_round <= po_round + 4'd1;
                end else begin
                    // Last round key consumed; hold key and index until the next load.
                    po_key_ready <= 1'b0;
                end
            end
        end
    end

`ifdef ARK_ROUND_KEY_OUT_EN
    assign po_round_key = key_q;
`endif

endmodule
